mm2axil: RTL and testbench

//  AXI4-Lite master bridge: turns the team's simple single-beat bus (a/d/rd/we -> spo/ready)

---
 rtl/mm2axil_pkg.sv | 29 ++
 rtl/mm2axil_if.sv | 38 +++
 rtl/mm2axil.sv | 151 +++++++++++++++
 tb/tb_mm2axil.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm2axil_pkg.sv
// Shared types for the simple-bus to AXI4-Lite master bridge.
package mm2axil_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  // AXI response codes
  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } axi_resp_e;

  // Bridge FSM states
  typedef enum logic [2:0] {
    StIdle,
    StWaddrData,
    StWresp,
    StRaddr,
    StRdata
  } state_e;

  // Anything other than OKAY is reported as an error to the initiator
  function automatic logic resp_is_err(logic [1:0] resp);
    return resp != RespOkay;
  endfunction

endpackage

// File: rtl/mm2axil_if.sv
// AXI4-Lite bus bundle; the bridge connects through the master modport.
interface mm2axil_if #(
  parameter int unsigned ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]             awaddr;
  logic [2:0]                        awprot;
  logic                              awvalid;
  logic                              awready;
  logic [mm2axil_pkg::DATA_W-1:0]    wdata;
  logic [mm2axil_pkg::STRB_W-1:0]    wstrb;
  logic                              wvalid;
  logic                              wready;
  logic [1:0]                        bresp;
  logic                              bvalid;
  logic                              bready;
  logic [ADDR_WIDTH-1:0]             araddr;
  logic [2:0]                        arprot;
  logic                              arvalid;
  logic                              arready;
  logic [mm2axil_pkg::DATA_W-1:0]    rdata;
  logic [1:0]                        rresp;
  logic                              rvalid;
  logic                              rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/mm2axil.sv
// Simple single-beat bus to AXI4-Lite master bridge, one transaction in flight.
module mm2axil
  import mm2axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [2:0]  AXI_PROT   = 3'b000
) (
  input  logic                  s_axi_clk,
  input  logic                  s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [DATA_W-1:0]     d,
  input  logic [STRB_W-1:0]     be,
  input  logic                  rd,
  input  logic                  we,
  output logic [DATA_W-1:0]     spo,
  output logic                  ready,
  output logic                  err,
  output logic                  busy,
  mm2axil_if.master             m_axi
);

  state_e                r_state,   w_state_d;
  logic [ADDR_WIDTH-1:0] r_addr,    w_addr_d;
  logic [DATA_W-1:0]     r_wdata,   w_wdata_d;
  logic [STRB_W-1:0]     r_wstrb,   w_wstrb_d;
  logic [DATA_W-1:0]     r_spo,     w_spo_d;
  logic                  r_awvalid, w_awvalid_d;
  logic                  r_wvalid,  w_wvalid_d;
  logic                  r_bready,  w_bready_d;
  logic                  r_arvalid, w_arvalid_d;
  logic                  r_rready,  w_rready_d;
  logic                  r_ready,   w_ready_d;
  logic                  r_err,     w_err_d;

  // State and output registers; reset drops every handshake output at once
  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_spo     <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_addr    <= w_addr_d;
      r_wdata   <= w_wdata_d;
      r_wstrb   <= w_wstrb_d;
      r_spo     <= w_spo_d;
      r_awvalid <= w_awvalid_d;
      r_wvalid  <= w_wvalid_d;
      r_bready  <= w_bready_d;
      r_arvalid <= w_arvalid_d;
      r_rready  <= w_rready_d;
      r_ready   <= w_ready_d;
      r_err     <= w_err_d;
    end
  end

  // Next-state and registered-output decode; all AXI outputs come from flops
  always_comb begin
    w_state_d   = r_state;
    w_addr_d    = r_addr;
    w_wdata_d   = r_wdata;
    w_wstrb_d   = r_wstrb;
    w_spo_d     = r_spo;
    w_awvalid_d = r_awvalid;
    w_wvalid_d  = r_wvalid;
    w_bready_d  = r_bready;
    w_arvalid_d = r_arvalid;
    w_rready_d  = r_rready;
    w_ready_d   = 1'b0;
    w_err_d     = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Write wins when both strobes arrive together
        if (we) begin
          w_addr_d    = a;
          w_wdata_d   = d;
          w_wstrb_d   = be;
          w_awvalid_d = 1'b1;
          w_wvalid_d  = 1'b1;
          w_state_d   = StWaddrData;
        end else if (rd) begin
          w_addr_d    = a;
          w_arvalid_d = 1'b1;
          w_state_d   = StRaddr;
        end
      end
      StWaddrData: begin
        // AW and W complete independently, in either order
        if (m_axi.awready) w_awvalid_d = 1'b0;
        if (m_axi.wready)  w_wvalid_d  = 1'b0;
        if (!w_awvalid_d && !w_wvalid_d) begin
          w_bready_d = 1'b1;
          w_state_d  = StWresp;
        end
      end
      StWresp: begin
        if (m_axi.bvalid) begin
          w_bready_d = 1'b0;
          w_ready_d  = 1'b1;
          w_err_d    = resp_is_err(m_axi.bresp);
          w_state_d  = StIdle;
        end
      end
      StRaddr: begin
        if (m_axi.arready) begin
          w_arvalid_d = 1'b0;
          w_rready_d  = 1'b1;
          w_state_d   = StRdata;
        end
      end
      StRdata: begin
        // Read data is captured even on an error response
        if (m_axi.rvalid) begin
          w_rready_d = 1'b0;
          w_spo_d    = m_axi.rdata;
          w_ready_d  = 1'b1;
          w_err_d    = resp_is_err(m_axi.rresp);
          w_state_d  = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign m_axi.awaddr  = r_addr;
  assign m_axi.awprot  = AXI_PROT;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = r_bready;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arprot  = AXI_PROT;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = r_rready;

  assign spo   = r_spo;
  assign ready = r_ready;
  assign err   = r_err;
  assign busy  = (r_state != StIdle);

endmodule

// File: tb/tb_mm2axil.sv
// Bench for mm2axil: the bench plays the AXI-Lite slave with programmable stalls and
// responses, and predicts results from a word-memory model of the requests issued.
module tb_mm2axil;

  localparam int LIMIT = 80;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, d;
  logic [3:0]  be;
  logic        rd, we;
  logic [31:0] spo;
  logic        ready, err, busy;

  always #5 clk = ~clk;

  mm2axil_if #(.ADDR_WIDTH(32)) axi ();

  mm2axil #(.ADDR_WIDTH(32), .AXI_PROT(3'b000)) dut (
    .s_axi_clk     (clk),
    .s_axi_aresetn (rst_n),
    .a             (a),
    .d             (d),
    .be            (be),
    .rd            (rd),
    .we            (we),
    .spo           (spo),
    .ready         (ready),
    .err           (err),
    .busy          (busy),
    .m_axi         (axi)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_mem [16];   // expected contents, from the requests made
  logic [31:0] slave_mem [16];   // contents built from what actually appeared on AXI
  logic [31:0] exp_spo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic slave_idle();
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;  axi.rresp = 2'b00;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_ready", ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 0);
    end
  endtask

  // One write: stall AW by awd cycles, W by wd, B by bd after both land
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int awd, input int wd, input int bd,
                          input logic [1:0] resp, input bit with_rd, input bit rd_busy,
                          input int exp_lat);
    int          cyc = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    bit          aw_hs = 0, w_hs = 0, aw_done = 0, w_done = 0, b_hs = 0, done = 0;
    bit          exp_ready;
    logic [31:0] s_addr = '0, s_data = '0;
    logic [3:0]  s_strb = '0;
    logic [3:0]  idx;
    chk("wr_start_busy", busy, 0);
    idx = addr[5:2];
    model_mem[idx] = merge(model_mem[idx], data, strb);
    a = addr; d = data; be = strb; we = 1'b1; rd = with_rd;
    while (!done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      we = 1'b0; rd = rd_busy && (cyc == 1);
      a = $urandom; d = $urandom; be = 4'($urandom);
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
      aw_hs = 0; w_hs = 0;
      exp_ready = b_hs;
      chk("wr_ready", ready, exp_ready);
      chk("wr_no_ar", axi.arvalid, 0);
      chk("wr_busy", busy, !exp_ready);
      if (exp_ready) begin
        chk("wr_err", err, resp != 2'b00);
        chk("wr_spo_held", spo, exp_spo);
        chk("wr_valids_low", {axi.awvalid, axi.wvalid, axi.bready}, 0);
        if (exp_lat >= 0) chk("wr_latency", cyc, exp_lat);
        done = 1;
      end else begin
        chk("wr_awvalid", axi.awvalid, !aw_done);
        if (!aw_done) begin
          chk("wr_awaddr", axi.awaddr, addr);
          chk("wr_awprot", axi.awprot, 0);
        end
        chk("wr_wvalid", axi.wvalid, !w_done);
        if (!w_done) begin
          chk("wr_wdata", axi.wdata, data);
          chk("wr_wstrb", axi.wstrb, strb);
        end
        chk("wr_bready", axi.bready, aw_done && w_done);
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        if (!aw_done && axi.awvalid) begin
          if (aw_cnt >= awd) begin axi.awready = 1'b1; aw_hs = 1; s_addr = axi.awaddr; end
          else aw_cnt++;
        end
        if (!w_done && axi.wvalid) begin
          if (w_cnt >= wd) begin
            axi.wready = 1'b1; w_hs = 1; s_data = axi.wdata; s_strb = axi.wstrb;
          end else w_cnt++;
        end
        if (aw_done && w_done) begin
          if (b_cnt >= bd) begin
            axi.bvalid = 1'b1; axi.bresp = resp;
            if (axi.bready) begin
              b_hs = 1;
              slave_mem[s_addr[5:2]] = merge(slave_mem[s_addr[5:2]], s_data, s_strb);
            end
          end else b_cnt++;
        end
      end
    end
    chk("wr_complete", done, 1);
    slave_idle();
  endtask

  // One read: stall AR by ard cycles and R by rdd; abort=1 resets during the data phase
  task automatic do_read(input logic [31:0] addr, input int ard, input int rdd,
                         input logic [1:0] resp, input bit abort, input int exp_lat);
    int          cyc = 0, ar_cnt = 0, r_cnt = 0;
    bit          ar_hs = 0, ar_done = 0, r_hs = 0, done = 0, exp_ready;
    logic [31:0] s_addr = '0, exp_data;
    chk("rd_start_busy", busy, 0);
    exp_data = model_mem[addr[5:2]];
    a = addr; rd = 1'b1; we = 1'b0;
    while (!done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      rd = 1'b0; a = $urandom;
      if (ar_hs) ar_done = 1;
      ar_hs = 0;
      exp_ready = r_hs;
      chk("rd_ready", ready, exp_ready);
      chk("rd_no_aw_w", {axi.awvalid, axi.wvalid}, 0);
      chk("rd_busy", busy, !exp_ready);
      if (exp_ready) begin
        chk("rd_err", err, resp != 2'b00);
        chk("rd_spo", spo, exp_data);
        chk("rd_valids_low", {axi.arvalid, axi.rready}, 0);
        if (exp_lat >= 0) chk("rd_latency", cyc, exp_lat);
        exp_spo = exp_data;
        done = 1;
      end else begin
        chk("rd_arvalid", axi.arvalid, !ar_done);
        if (!ar_done) begin
          chk("rd_araddr", axi.araddr, addr);
          chk("rd_arprot", axi.arprot, 0);
        end
        chk("rd_rready", axi.rready, ar_done);
        axi.arready = 1'b0;
        if (!ar_done && axi.arvalid) begin
          if (ar_cnt >= ard) begin axi.arready = 1'b1; ar_hs = 1; s_addr = axi.araddr; end
          else ar_cnt++;
        end
        if (ar_done && abort) begin
          rst_n = 1'b0;
          #1;
          chk("rst_handshakes", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready},
              0);
          chk("rst_status", {ready, err, busy}, 0);
          chk("rst_spo", spo, 0);
          exp_spo = '0;
          slave_idle();
          @(negedge clk);
          rst_n = 1'b1;
          idle_check(4);
          done = 1;
        end else if (ar_done) begin
          if (r_cnt >= rdd) begin
            axi.rvalid = 1'b1; axi.rresp = resp; axi.rdata = slave_mem[s_addr[5:2]];
            if (axi.rready) r_hs = 1;
          end else r_cnt++;
        end
      end
    end
    chk("rd_complete", done, 1);
    slave_idle();
  endtask

  initial begin
    logic [31:0] r_addr, r_data;
    rst_n = 1'b0; a = '0; d = '0; be = '0; rd = 1'b0; we = 1'b0;
    slave_idle();
    for (int i = 0; i < 16; i++) begin model_mem[i] = '0; slave_mem[i] = '0; end
    exp_spo = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_status", {ready, err, busy}, 0);
    chk("reset_spo", spo, 0);
    chk("reset_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
    chk("reset_awaddr", axi.awaddr, 0);
    chk("reset_wdata", axi.wdata, 0);
    chk("reset_wstrb", axi.wstrb, 0);
    rst_n = 1'b1;
    idle_check(1);

    // Zero-wait write, ready three cycles after the request
    do_write(32'h0, 32'hA5, 4'h1, 0, 0, 0, 2'b00, 0, 0, 3);
    // Zero-wait read back
    do_read(32'h0, 0, 0, 2'b00, 0, 3);
    // Stalled read of a known word
    model_mem[4'h3] = 32'h1234_5678;
    slave_mem[4'h3] = 32'h1234_5678;
    do_read(32'hC, 3, 2, 2'b00, 0, -1);
    // W four cycles ahead of AW, then AW ahead of W
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 4, 0, 0, 2'b00, 0, 0, -1);
    do_write(32'h14, 32'hCAFE_F00D, 4'hF, 0, 4, 1, 2'b00, 0, 0, -1);
    do_read(32'h10, 1, 0, 2'b00, 0, -1);
    // Error responses
    do_write(32'h18, 32'h0102_0304, 4'h6, 0, 0, 0, 2'b10, 0, 0, -1);
    do_read(32'h18, 0, 1, 2'b11, 0, -1);
    // Read dropped when paired with a write, and ignored while busy
    do_write(32'h1C, 32'h5555_AAAA, 4'hF, 1, 1, 0, 2'b00, 1, 0, -1);
    do_write(32'h20, 32'h7777_8888, 4'h3, 0, 2, 2, 2'b00, 0, 1, -1);
    idle_check(3);
    // LCR-style byte write and read back
    do_write(32'hC, 32'h03, 4'h1, 0, 0, 0, 2'b00, 0, 0, 3);
    do_read(32'hC, 0, 0, 2'b00, 0, 3);

    // Randomized back-to-back traffic
    for (int n = 0; n < 50; n++) begin
      logic [1:0] resp;
      r_addr = $urandom;
      r_data = $urandom;
      resp = ($urandom_range(0, 7) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 0)
        do_write(r_addr, r_data, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2), resp, 0, 0, -1);
      else
        do_read(r_addr, $urandom_range(0, 3), $urandom_range(0, 3), resp, 0, -1);
      if ($urandom_range(0, 3) == 0) idle_check(1);
    end

    // Reset in the read-data phase, then normal traffic again
    do_read(32'h24, 1, 5, 2'b00, 1, -1);
    do_write(32'h28, 32'h0BAD_F00D, 4'hF, 0, 0, 0, 2'b00, 0, 0, 3);
    do_read(32'h28, 0, 0, 2'b00, 0, 3);
    idle_check(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
